vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout (640x480@60 by default).
// Define VGA_PALETTE_EN to map pixel_in through a 16-entry RGB palette instead of greyscale.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pixel_in,
  output logic       read,
  output logic       reset_read_ptr,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS        = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS        = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [5:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;
  logic          active;
  logic          h_last;
  logic [5:0]    pix_rgb;

  assign h_last = (h_cnt_q == H_LAST);
  assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

  // One read per pixel pair; reset is folded in so an aborted scan never advances the pointer.
  assign read           = active & h_cnt_q[0] & ~reset;
  assign reset_read_ptr = reset | ((h_cnt_q == '0) && (v_cnt_q == V_VIS));

`ifdef VGA_PALETTE_EN
  // Black -> blue -> red -> yellow -> white, packed as {r,g,b}.
  always_comb begin
    pix_rgb = 6'b000000;
    case (pixel_in)
      4'd0:  pix_rgb = 6'b00_00_00;
      4'd1:  pix_rgb = 6'b00_00_01;
      4'd2:  pix_rgb = 6'b00_00_10;
      4'd3:  pix_rgb = 6'b00_00_11;
      4'd4:  pix_rgb = 6'b01_00_11;
      4'd5:  pix_rgb = 6'b10_00_10;
      4'd6:  pix_rgb = 6'b11_00_01;
      4'd7:  pix_rgb = 6'b11_00_00;
      4'd8:  pix_rgb = 6'b11_01_00;
      4'd9:  pix_rgb = 6'b11_10_00;
      4'd10: pix_rgb = 6'b11_11_00;
      4'd11: pix_rgb = 6'b11_11_01;
      4'd12: pix_rgb = 6'b11_11_01;
      4'd13: pix_rgb = 6'b11_11_10;
      4'd14: pix_rgb = 6'b11_11_10;
      4'd15: pix_rgb = 6'b11_11_11;
      default: pix_rgb = 6'b00_00_00;
    endcase
  end
`else
  logic unused_pixel_lsbs;
  assign unused_pixel_lsbs = ^pixel_in[1:0];
  assign pix_rgb = {3{pixel_in[3:2]}};
`endif

  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    rgb_d         = active ? pix_rgb : 6'b000000;
    hsync_d       = ~((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
    vsync_d       = ~((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // All visible outputs share one register stage so they stay aligned to each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= 6'b000000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign r           = rgb_q[5:4];
  assign g           = rgb_q[3:2];
  assign b           = rgb_q[1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule
